bram_lap_arbiter: RTL
=====================

Name: bram_lap_arbiter

Overview:
Shares the chronometer's single inferred BRAM between two requesters: the Wishbone slave path (start/wr_rd) and a lap-capture path that logs the 16-bit chronometer value on every lap pulse. The block owns the write pointer, lap count and overflow/drop status of the lap log. It performs at most one RAM access per cycle, arbitrating round-robin between the two requesters. It sits between wb_slave and bram_inf inside the slave interface.

Parameters:
DATA_SIZE, 16, RAM word width and lap value width
ADDR_SIZE, 10, RAM address bits; log depth = 2**ADDR_SIZE

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset; synchronous, active-high
wb_req  in  1  Wishbone access request (level), held until wb_grant
wb_we  in  1  1 = write, 0 = read; stable while wb_req=1
wb_addr  in  ADDR_SIZE  Wishbone word address
wb_wdata  in  DATA_SIZE  Wishbone write data
wb_grant  out  1  one-cycle pulse: access completed
wb_rdata  out  DATA_SIZE  read data, valid when wb_grant=1 and wb_we=0
lap_i  in  1  lap capture pulse, one cycle
value  in  16  current chronometer value
clear_i  in  1  clears pointer, count and sticky flags
lap_count  out  ADDR_SIZE+1  laps stored, saturates at 2**ADDR_SIZE
overflow  out  1  sticky: log wrapped and overwrote an entry
lap_drop  out  1  sticky: lap pulse lost while one was still pending
ram_wr_en  out  1  BRAM write enable
ram_wr_addr  out  ADDR_SIZE  BRAM write address
ram_wr_data  out  DATA_SIZE  BRAM write data
ram_rd_addr  out  ADDR_SIZE  BRAM read address
ram_rd_data  in  DATA_SIZE  BRAM read data, one-cycle registered latency

Behaviour:
- Reset values: all outputs 0; wr_ptr=0, pending=0, last_grant=WB, FSM=IDLE. Reset mid-read abandons the read with no wb_grant.
- Lap capture: lap_i=1 with pending=0 sets pending=1 and latches value into lap_buf that cycle. If lap_i=1 while pending=1, the new value is discarded and lap_drop is set. A pending lap cleared in the same cycle accepts the new lap.
- FSM states: IDLE, LAP_WR, WB_WR, WB_RD, RD_DATA.
- IDLE: if exactly one of pending or wb_req is active, go to that requester's state. If both are active, grant the requester not in last_grant.
- LAP_WR (1 cycle): ram_wr_en=1, addr=wr_ptr, data=lap_buf. wr_ptr increments mod 2**ADDR_SIZE. lap_count increments unless already 2**ADDR_SIZE; if it was already 2**ADDR_SIZE, set overflow. Clear pending, set last_grant=LAP, go to IDLE.
- WB_WR (1 cycle): ram_wr_en=1, addr=wb_addr, data=wb_wdata, wb_grant=1, last_grant=WB, go to IDLE.
- WB_RD: ram_rd_addr=wb_addr, go to RD_DATA. RD_DATA: wb_rdata=ram_rd_data, wb_grant=1, last_grant=WB, go to IDLE.
- Latency from request seen in IDLE (cycle N): write completes at N+1; read completes at N+2. Worst-case wait for a waiting requester is one extra access.
- ram_rd_addr holds wb_addr when not in WB_RD. ram_wr_en=0 outside LAP_WR and WB_WR.
- clear_i: same cycle resets wr_ptr, lap_count, overflow and lap_drop to 0. It does not abort an in-flight access. If it coincides with LAP_WR, the write still lands and the pointer/count end at 0.
- A WB write to an address inside the log is allowed. No protection is applied.

Decomposition:
- Package chrono_pkg: FSM state encoding (localparams), GRANT_WB/GRANT_LAP constants, LOG_DEPTH = 2**ADDR_SIZE.
- One natural sub-module: lap_capture (pending flag, lap_buf, lap_drop). Arbiter FSM and pointer/count stay in the top module.

Test Plan:
- Reset then lap_i with value=16'h0123 -> LAP_WR writes addr 0, data 0x0123; lap_count=1; wr_ptr=1.
- wb_req write addr 5, data 0xBEEF, then read addr 5 -> write grant at N+1; read grant at N+2 with wb_rdata=0xBEEF.
- wb_req (read) and pending lap in the same cycle after last_grant=WB -> LAP_WR first, then WB read completes within 3 further cycles.
- lap_i on two consecutive cycles while WB read in progress -> first value logged, lap_drop=1, lap_count increases by 1 only.
- 1025 laps with ADDR_SIZE=10 -> lap_count saturates at 1024, overflow=1, address 0 holds the 1025th value.
- clear_i with lap_count=7 and overflow=1 -> all 0 next cycle; next lap written at addr 0.

Source files
------------

// File: rtl/chrono_pkg.sv
// Shared constants for the chronometer BRAM arbiter: FSM encoding, grant ids, log depth.
package chrono_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_LAP_WR  = 3'd1;
  localparam logic [STATE_W-1:0] ST_WB_WR   = 3'd2;
  localparam logic [STATE_W-1:0] ST_WB_RD   = 3'd3;
  localparam logic [STATE_W-1:0] ST_RD_DATA = 3'd4;

  localparam logic GRANT_WB  = 1'b0;
  localparam logic GRANT_LAP = 1'b1;

  localparam int unsigned ADDR_SIZE_DEFAULT = 10;
  localparam int unsigned LOG_DEPTH         = 2 ** ADDR_SIZE_DEFAULT;

  function automatic int unsigned log_depth(input int unsigned addr_size);
    return 32'd1 << addr_size;
  endfunction

endpackage

// File: rtl/lap_capture.sv
// Holds one pending lap value until the arbiter writes it; flags laps lost while busy.
module lap_capture #(
  parameter int unsigned DATA_SIZE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 lap_i,
  input  logic [15:0]          value,
  input  logic                 take,
  input  logic                 clear_i,
  output logic                 pending,
  output logic [DATA_SIZE-1:0] lap_buf,
  output logic                 lap_drop
);

  // A lap arriving in the cycle the buffer is consumed refills it rather than being dropped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending  <= 1'b0;
      lap_buf  <= '0;
      lap_drop <= 1'b0;
    end else begin
      if (lap_i && (!pending || take)) begin
        pending <= 1'b1;
        lap_buf <= DATA_SIZE'(value);
      end else if (take) begin
        pending <= 1'b0;
      end

      if (clear_i) begin
        lap_drop <= 1'b0;
      end else if (lap_i && pending && !take) begin
        lap_drop <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bram_lap_arbiter.sv
// Round-robin arbiter sharing one BRAM between the Wishbone slave and the lap logger.
module bram_lap_arbiter
  import chrono_pkg::*;
#(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned ADDR_SIZE = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 wb_req,
  input  logic                 wb_we,
  input  logic [ADDR_SIZE-1:0] wb_addr,
  input  logic [DATA_SIZE-1:0] wb_wdata,
  output logic                 wb_grant,
  output logic [DATA_SIZE-1:0] wb_rdata,
  input  logic                 lap_i,
  input  logic [15:0]          value,
  input  logic                 clear_i,
  output logic [ADDR_SIZE:0]   lap_count,
  output logic                 overflow,
  output logic                 lap_drop,
  output logic                 ram_wr_en,
  output logic [ADDR_SIZE-1:0] ram_wr_addr,
  output logic [DATA_SIZE-1:0] ram_wr_data,
  output logic [ADDR_SIZE-1:0] ram_rd_addr,
  input  logic [DATA_SIZE-1:0] ram_rd_data
);

  localparam logic [ADDR_SIZE:0] COUNT_FULL = (ADDR_SIZE + 1)'(log_depth(ADDR_SIZE));

  logic [STATE_W-1:0]   state;
  logic [STATE_W-1:0]   state_next;
  logic                 last_grant;
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic                 pending;
  logic [DATA_SIZE-1:0] lap_buf;
  logic                 lap_take;

  lap_capture #(
    .DATA_SIZE (DATA_SIZE)
  ) u_lap_capture (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .lap_i    (lap_i),
    .value    (value),
    .take     (lap_take),
    .clear_i  (clear_i),
    .pending  (pending),
    .lap_buf  (lap_buf),
    .lap_drop (lap_drop)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Contention goes to whichever side did not win last.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (pending && (!wb_req || last_grant == GRANT_WB)) begin
          state_next = ST_LAP_WR;
        end else if (wb_req) begin
          state_next = wb_we ? ST_WB_WR : ST_WB_RD;
        end
      end
      ST_WB_RD:   state_next = ST_RD_DATA;
      ST_LAP_WR,
      ST_WB_WR,
      ST_RD_DATA: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wb_grant    = 1'b0;
    wb_rdata    = '0;
    ram_wr_en   = 1'b0;
    ram_wr_addr = '0;
    ram_wr_data = '0;
    ram_rd_addr = wb_addr;
    lap_take    = 1'b0;
    case (state)
      ST_LAP_WR: begin
        ram_wr_en   = 1'b1;
        ram_wr_addr = wr_ptr;
        ram_wr_data = lap_buf;
        lap_take    = 1'b1;
      end
      ST_WB_WR: begin
        ram_wr_en   = 1'b1;
        ram_wr_addr = wb_addr;
        ram_wr_data = wb_wdata;
        wb_grant    = 1'b1;
      end
      ST_RD_DATA: begin
        wb_grant = 1'b1;
        wb_rdata = ram_rd_data;
      end
      default: ;
    endcase
  end

  // Log bookkeeping; clear overrides a coincident lap write so pointer and count end at 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      lap_count  <= '0;
      overflow   <= 1'b0;
      last_grant <= GRANT_WB;
    end else begin
      if (state == ST_LAP_WR) begin
        last_grant <= GRANT_LAP;
        wr_ptr     <= wr_ptr + ADDR_SIZE'(1);
        if (lap_count == COUNT_FULL) begin
          overflow <= 1'b1;
        end else begin
          lap_count <= lap_count + (ADDR_SIZE + 1)'(1);
        end
      end
      if (state == ST_WB_WR || state == ST_RD_DATA) begin
        last_grant <= GRANT_WB;
      end
      if (clear_i) begin
        wr_ptr    <= '0;
        lap_count <= '0;
        overflow  <= 1'b0;
      end
    end
  end

endmodule
